// File: rtl/text_console_writer.sv
// Cursor-driven writer for the text overlay character table.
// Optional per-row clear on row entry: define TEXT_CONSOLE_LINE_CLEAR_EN.
module text_console_writer #(
    parameter int COLUMNS       = 12,
    parameter int ROWS          = 2,
    parameter int FONT_NUM_CHAR = 256,
    parameter int BLANK_CHAR    = 0,
    localparam int CW = $clog2(FONT_NUM_CHAR),
    localparam int XW = $clog2(COLUMNS),
    localparam int YW = $clog2(ROWS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [CW-1:0] i_char,
    input  logic          i_char_dv,
    output logic          o_ready,
    output logic [CW-1:0] o_wr_character,
    output logic [XW-1:0] o_wr_x_pos,
    output logic [YW-1:0] o_wr_y_pos,
    output logic          o_wr_en,
    output logic [XW-1:0] o_cursor_x,
    output logic [YW-1:0] o_cursor_y,
    output logic          o_busy
);

`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
    typedef enum logic [1:0] {IDLE, CLEAR_ALL, CLEAR_ROW} state_t;
`else
    typedef enum logic [1:0] {IDLE, CLEAR_ALL} state_t;
`endif

    localparam logic [CW-1:0] LF    = CW'(8'h0A);
    localparam logic [CW-1:0] CR    = CW'(8'h0D);
    localparam logic [CW-1:0] BS    = CW'(8'h08);
    localparam logic [CW-1:0] FF    = CW'(8'h0C);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CHAR);
    localparam logic [XW-1:0] X_MAX = XW'(COLUMNS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

    state_t        state;
    logic [XW-1:0] clr_x;
    logic [YW-1:0] clr_y;
    logic          clr_done;
    logic [YW-1:0] next_y;

    assign next_y  = (o_cursor_y == Y_MAX) ? '0 : o_cursor_y + YW'(1);
    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            o_cursor_x     <= '0;
            o_cursor_y     <= '0;
            o_wr_en        <= 1'b0;
            o_wr_character <= '0;
            o_wr_x_pos     <= '0;
            o_wr_y_pos     <= '0;
            clr_x          <= '0;
            clr_y          <= '0;
            clr_done       <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_char_dv) begin
                        case (i_char)
                            LF: begin
                                o_cursor_x <= '0;
                                o_cursor_y <= next_y;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
                                state          <= CLEAR_ROW;
                                o_wr_en        <= 1'b1;
                                o_wr_character <= BLANK;
                                o_wr_x_pos     <= '0;
                                o_wr_y_pos     <= next_y;
                                clr_x          <= XW'(1);
                                clr_y          <= next_y;
                                clr_done       <= 1'b0;
`endif
                            end
                            CR: o_cursor_x <= '0;
                            BS: begin
                                if (o_cursor_x != '0)
                                    o_cursor_x <= o_cursor_x - XW'(1);
                            end
                            FF: begin
                                // first blank goes out with the accept
                                state          <= CLEAR_ALL;
                                o_wr_en        <= 1'b1;
                                o_wr_character <= BLANK;
                                o_wr_x_pos     <= '0;
                                o_wr_y_pos     <= '0;
                                clr_x          <= XW'(1);
                                clr_y          <= '0;
                                clr_done       <= 1'b0;
                            end
                            default: begin
                                o_wr_en        <= 1'b1;
                                o_wr_character <= i_char;
                                o_wr_x_pos     <= o_cursor_x;
                                o_wr_y_pos     <= o_cursor_y;
                                if (o_cursor_x == X_MAX) begin
                                    o_cursor_x <= '0;
                                    o_cursor_y <= next_y;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
                                    state    <= CLEAR_ROW;
                                    clr_x    <= '0;
                                    clr_y    <= next_y;
                                    clr_done <= 1'b0;
`endif
                                end else begin
                                    o_cursor_x <= o_cursor_x + XW'(1);
                                end
                            end
                        endcase
                    end
                end
                CLEAR_ALL: begin
                    if (clr_done) begin
                        state      <= IDLE;
                        o_cursor_x <= '0;
                        o_cursor_y <= '0;
                    end else begin
                        o_wr_en        <= 1'b1;
                        o_wr_character <= BLANK;
                        o_wr_x_pos     <= clr_x;
                        o_wr_y_pos     <= clr_y;
                        if (clr_x == X_MAX) begin
                            clr_x <= '0;
                            if (clr_y == Y_MAX) clr_done <= 1'b1;
                            else clr_y <= clr_y + YW'(1);
                        end else begin
                            clr_x <= clr_x + XW'(1);
                        end
                    end
                end
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
                CLEAR_ROW: begin
                    if (clr_done) begin
                        state <= IDLE;
                    end else begin
                        o_wr_en        <= 1'b1;
                        o_wr_character <= BLANK;
                        o_wr_x_pos     <= clr_x;
                        o_wr_y_pos     <= clr_y;
                        if (clr_x == X_MAX) clr_done <= 1'b1;
                        else clr_x <= clr_x + XW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Randomized bench for text_console_writer with a queue-based write model.
module tb_text_console_writer;

    localparam int COLS = 12;
    localparam int ROWS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_char = '0;
    logic       i_char_dv = 1'b0;
    logic       o_ready, o_wr_en, o_busy;
    logic [7:0] o_wr_character;
    logic [3:0] o_wr_x_pos, o_cursor_x;
    logic [0:0] o_wr_y_pos, o_cursor_y;

    text_console_writer #(
        .COLUMNS(COLS), .ROWS(ROWS), .FONT_NUM_CHAR(256), .BLANK_CHAR(0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_char(i_char), .i_char_dv(i_char_dv),
        .o_ready(o_ready), .o_wr_character(o_wr_character),
        .o_wr_x_pos(o_wr_x_pos), .o_wr_y_pos(o_wr_y_pos), .o_wr_en(o_wr_en),
        .o_cursor_x(o_cursor_x), .o_cursor_y(o_cursor_y), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: cursor arithmetic plus a queue of pending blank writes.
    typedef struct { int c; int x; int y; } wr_t;
    wr_t q[$];
    int  mx = 0, my = 0, m_char = 0, m_wx = 0, m_wy = 0, acc_cnt = 0;
    bit  m_ready = 1'b1, m_wr = 1'b0;

    task automatic push_row(input int y);
        for (int x = 0; x < COLS; x++) q.push_back('{0, x, y});
    endtask

    initial begin : model
        bit newrow, popped;
        wr_t w;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mx = 0; my = 0; m_wr = 0; m_ready = 1; q.delete();
            end else begin
                newrow = 0; popped = 0; m_wr = 0;
                if (m_ready && i_char_dv) begin
                    acc_cnt++;
                    case (i_char)
                        8'h0A: begin mx = 0; my = (my + 1) % ROWS; newrow = 1; end
                        8'h0D: mx = 0;
                        8'h08: if (mx > 0) mx--;
                        8'h0C: begin
                            for (int y = 0; y < ROWS; y++) push_row(y);
                            mx = 0; my = 0;
                        end
                        default: begin
                            m_wr = 1; m_char = i_char; m_wx = mx; m_wy = my;
                            if (mx == COLS - 1) begin
                                mx = 0; my = (my + 1) % ROWS; newrow = 1;
                            end else mx++;
                        end
                    endcase
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
                    if (newrow) push_row(my);
`endif
                end
                if (!m_wr && q.size() > 0) begin
                    w = q.pop_front();
                    m_wr = 1; m_char = w.c; m_wx = w.x; m_wy = w.y; popped = 1;
                end
                m_ready = (q.size() == 0) && !popped;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("ready", o_ready, m_ready);
            chk("busy", o_busy, !m_ready);
            chk("wr_en", o_wr_en, m_wr);
            if (m_wr) begin
                chk("wr_char", o_wr_character, m_char);
                chk("wr_x", o_wr_x_pos, m_wx);
                chk("wr_y", o_wr_y_pos, m_wy);
            end
            if (m_ready) begin
                chk("cur_x", o_cursor_x, mx);
                chk("cur_y", o_cursor_y, my);
            end
        end
    end

    task automatic send(input logic [7:0] c, output int waited);
        int start;
        start = acc_cnt;
        i_char = c; i_char_dv = 1'b1; waited = 0;
        while (acc_cnt == start && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (acc_cnt == start) chk("send_timeout", 0, 1);
        i_char_dv = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (!m_ready && g < 200) begin @(negedge clk); g++; end
        if (!m_ready) chk("idle_timeout", 0, 1);
    endtask

    initial begin : stim
        int w, nb, nw, g, r;
        logic [7:0] c;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_cur_x", o_cursor_x, 0);
        chk("rst_wr_x", o_wr_x_pos, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_busy", o_busy, 0);

        send(8'h41, w);
        chk("a_wr_en", o_wr_en, 1);
        chk("a_char", o_wr_character, 8'h41);
        chk("a_pos", {28'd0, o_wr_x_pos}, 0);
        chk("a_cur_x", o_cursor_x, 1);
        chk("a_ready", o_ready, 1);

        send(8'h0C, w);
        nb = 0; nw = 0; g = 0;
        while (o_busy && g < 100) begin
            nb++;
            if (o_wr_en && o_wr_character == 8'h00) nw++;
            @(negedge clk); g++;
        end
        chk("ff_busy_cycles", nb, 24);
        chk("ff_blank_writes", nw, 24);
        chk("ff_ready_after", o_ready, 1);

        for (int i = 0; i < 13; i++) send(8'h42, w);
        chk("b13_cur_x", o_cursor_x, 1);
        chk("b13_cur_y", o_cursor_y, 1);
        chk("b13_wr_y", o_wr_y_pos, 1);

        for (int i = 0; i < 10; i++) send(8'h30 + 8'(i), w);
        send(8'h43, w);
        chk("c_wr_x", o_wr_x_pos, 11);
        chk("c_wr_y", o_wr_y_pos, 1);
        chk("c_cur_x", o_cursor_x, 0);
        chk("c_cur_y", o_cursor_y, 0);
        wait_idle();

        for (int i = 0; i < 5; i++) send(8'h61, w);
        send(8'h08, w);
        chk("bs_cur_x", o_cursor_x, 4);
        chk("bs_no_wr", o_wr_en, 0);
        send(8'h0D, w);
        chk("cr_cur_x", o_cursor_x, 0);
        for (int i = 0; i < 3; i++) send(8'h62, w);
        send(8'h0A, w);
        chk("lf_cur_x", o_cursor_x, 0);
        chk("lf_cur_y", o_cursor_y, 1);
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
        nb = 0; nw = 0; g = 0;
        while (!o_ready && g < 100) begin
            nb++;
            if (o_wr_en && o_wr_y_pos == 1'b1) nw++;
            @(negedge clk); g++;
        end
        chk("lc_busy_cycles", nb, 12);
        chk("lc_row_writes", nw, 12);
`endif
        send(8'h08, w);
        chk("bs0_cur_x", o_cursor_x, 0);
        chk("bs0_cur_y", o_cursor_y, 1);

        send(8'h0C, w);
        send(8'h41, w);
        chk("held_wait", w, 25);
        chk("held_char", o_wr_character, 8'h41);
        chk("held_cur_x", o_cursor_x, 1);

        send(8'h0C, w);
        nw = 0; g = 0;
        while (g < 50) begin
            if (o_wr_en) nw++;
            if (nw == 10) break;
            @(negedge clk); g++;
        end
        chk("mid_seen10", nw, 10);
        #2 rst = 1'b1;
        #1;
        chk("mid_wr_en", o_wr_en, 0);
        chk("mid_cur_x", o_cursor_x, 0);
        chk("mid_busy", o_busy, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        nw = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_wr_en) nw++;
        end
        chk("mid_no_writes", nw, 0);
        chk("mid_ready", o_ready, 1);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) c = 8'h0C;
            else if (r < 13) c = 8'h0A;
            else if (r < 20) c = 8'h0D;
            else if (r < 28) c = 8'h08;
            else c = 8'($urandom_range(0, 255));
            send(c, w);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
